// File: rtl/cnc_pkg.sv
// Shared types for the CNC window processor: reduction modes and frame FSM states.
package cnc_pkg;

  typedef enum logic [1:0] {MODE_SUM, MODE_MAX, MODE_MIN, MODE_AVG} cnc_mode_e;

  typedef enum logic {ST_IDLE, ST_ACC} cnc_state_e;

endpackage

// File: rtl/cnc_lane.sv
// One lane of the window processor: running accumulator with sum/max/min/avg selection.
module cnc_lane
  import cnc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 17,
  parameter int WIN    = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              update,
  input  cnc_mode_e         mode_q,
  input  logic [DATA_W-1:0] din,
  output logic [OUT_W-1:0]  result
);

  localparam int SHIFT = $clog2(WIN);

  function automatic logic [OUT_W-1:0] avg_trunc(input logic [OUT_W-1:0] sum);
    return sum >> SHIFT;
  endfunction

  logic [OUT_W-1:0] acc_p0;
  logic [OUT_W-1:0] din_ext;
  logic [OUT_W-1:0] acc_nxt;

  assign din_ext = OUT_W'(din);

  // result reflects the accumulator including the current sample, so the
  // top can capture it on the same edge that accepts the last sample
  always_comb begin
    acc_nxt = acc_p0 + din_ext;
    case (mode_q)
      MODE_MAX: acc_nxt = (din_ext > acc_p0) ? din_ext : acc_p0;
      MODE_MIN: acc_nxt = (din_ext < acc_p0) ? din_ext : acc_p0;
      default:  acc_nxt = acc_p0 + din_ext;
    endcase
    result = (mode_q == MODE_AVG) ? avg_trunc(acc_nxt) : acc_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_p0 <= '0;
    end else if (load) begin
      acc_p0 <= din_ext;
    end else if (update) begin
      acc_p0 <= acc_nxt;
    end
  end

endmodule

// File: rtl/cnc_window_proc.sv
// Multi-lane window processor: frame FSM, sample counter, mode latch and result register.
module cnc_window_proc
  import cnc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CH     = 1,
  parameter int WIN    = 512,
  parameter int OUT_W  = 17
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_en,
  input  logic [1:0]          mode,
  input  logic [CH*DATA_W-1:0] in_data,
  output logic                out_en,
  output logic [CH*OUT_W-1:0] out_data,
  output logic                busy
);

  localparam int CNT_W = $clog2(WIN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN - 1);

  if (WIN < 2 || (WIN & (WIN - 1)) != 0) begin : g_bad_win
    $error("cnc_window_proc: WIN must be a power of two and at least 2");
  end
  if (OUT_W < DATA_W + $clog2(WIN)) begin : g_bad_out_w
    $error("cnc_window_proc: OUT_W too narrow for DATA_W + log2(WIN)");
  end

  cnc_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  cnc_mode_e        mode_q;
  logic             load, update, fire;
  logic [CH*OUT_W-1:0] lane_res;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mode_q <= MODE_SUM;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) mode_q <= cnc_mode_e'(mode);
    end
  end

  // counter wraps to zero naturally on the WIN-th sample
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    update    = 1'b0;
    fire      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_en) begin
          load      = 1'b1;
          cnt_nxt   = CNT_W'(1);
          state_nxt = ST_ACC;
        end
      end
      ST_ACC: begin
        if (in_en) begin
          update  = 1'b1;
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == LAST) begin
            fire      = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  for (genvar i = 0; i < CH; i++) begin : g_lane
    cnc_lane #(
      .DATA_W(DATA_W),
      .OUT_W (OUT_W),
      .WIN   (WIN)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .update(update),
      .mode_q(mode_q),
      .din   (in_data[i*DATA_W +: DATA_W]),
      .result(lane_res[i*OUT_W +: OUT_W])
    );
  end

  // output register stage: results held until the next frame completes
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_en   <= 1'b0;
      out_data <= '0;
    end else begin
      out_en <= fire;
      if (fire) out_data <= lane_res;
    end
  end

  assign busy = (state == ST_ACC);

endmodule
